// File: rtl/demux_pkg.sv
// demux_pkg: shared lane count, select width and one-hot lane type for the demux/decoder blocks
package demux_pkg;

    localparam int N_LANES = 8;
    localparam int SEL_W   = 3;

    typedef logic [N_LANES-1:0] lane_oh_t;

    function automatic lane_oh_t onehot_of(input logic [SEL_W-1:0] sel);
        return lane_oh_t'(1) << sel;
    endfunction

endpackage

// File: rtl/onehot_dec3to8.sv
// onehot_dec3to8: combinational 3-to-8 one-hot decoder, bit k set when sel == k
module onehot_dec3to8
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    output lane_oh_t         onehot
);

    // every sel code maps to exactly one lane; there is no idle code
    always_comb begin
        onehot = onehot_of(sel);
    end

endmodule

// File: rtl/demux_1to8.sv
// demux_1to8: registered 1-to-8 demux, selected lane gets in, the other seven are zeroed
module demux_1to8
    import demux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in,
    input  logic [SEL_W-1:0]          sel,
    output logic [N_LANES*DATA_W-1:0] out
);

    lane_oh_t                  onehot;
    logic [N_LANES*DATA_W-1:0] out_d;
    logic [N_LANES*DATA_W-1:0] out_q;

    onehot_dec3to8 u_dec (
        .sel    (sel),
        .onehot (onehot)
    );

    // gate in onto each lane by its decode bit; the whole word is rebuilt every cycle so no stale lane survives
    always_comb begin
        out_d = '0;
        for (int k = 0; k < N_LANES; k++)
            out_d[k*DATA_W +: DATA_W] = in & {DATA_W{onehot[k]}};
    end

    // single output register; reset wins over the incoming in/sel pair
    always_ff @(posedge clk) begin
        out_q <= rst ? '0 : out_d;
    end

    assign out = out_q;

endmodule

// File: tb/tb_demux_1to8.sv
// tb_demux_1to8: directed and random checks of DATA_W=1 and DATA_W=4 demux instances against an arithmetic model
module tb_demux_1to8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in1;
    logic [3:0]  in4;
    logic [2:0]  sel;
    logic [7:0]  out1;
    logic [31:0] out4;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    demux_1to8 #(.DATA_W(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .in  (in1),
        .sel (sel),
        .out (out1)
    );

    demux_1to8 #(.DATA_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .in  (in4),
        .sel (sel),
        .out (out4)
    );

    function automatic logic [7:0] model1(input logic r, input logic i, input logic [2:0] s);
        return r ? 8'h00 : (8'(i) << s);
    endfunction

    function automatic logic [31:0] model4(input logic r, input logic [3:0] i, input logic [2:0] s);
        return r ? 32'h0 : (32'(i) << (4 * int'(s)));
    endfunction

    task automatic step(input logic r, input logic i1, input logic [3:0] i4, input logic [2:0] s,
                        input logic [7:0] want1, input string tag);
        logic [7:0]  e1;
        logic [31:0] e4;
        @(negedge clk);
        rst = r;
        in1 = i1;
        in4 = i4;
        sel = s;
        e1 = model1(r, i1, s);
        e4 = model4(r, i4, s);
        @(posedge clk);
        #1;
        checks++;
        assert (out1 === e1) else begin
            failures++;
            $error("FAIL %s out1 got=%h exp=%h", tag, out1, e1);
        end
        checks++;
        assert (out1 === want1) else begin
            failures++;
            $error("FAIL %s out1_plan got=%h exp=%h", tag, out1, want1);
        end
        checks++;
        assert (out4 === e4) else begin
            failures++;
            $error("FAIL %s out4 got=%h exp=%h", tag, out4, e4);
        end
        checks++;
        assert ($countones(out1) <= 1) else begin
            failures++;
            $error("FAIL %s onelane got=%h exp=at_most_one_bit", tag, out1);
        end
    endtask

    initial begin
        logic        r;
        logic        i1;
        logic [2:0]  s;
        logic [7:0]  w;
        rst = 1'b1;
        in1 = 1'b1;
        in4 = 4'h0;
        sel = 3'd5;
        step(1'b1, 1'b1, 4'hA, 3'd5, 8'h00, "reset0");
        step(1'b1, 1'b1, 4'hA, 3'd5, 8'h00, "reset1");
        step(1'b0, 1'b1, 4'hA, 3'd5, 8'h20, "release");
        for (int k = 0; k < 8; k++)
            step(1'b0, 1'b0, 4'h0, 3'(k), 8'h00, "zero_sweep");
        for (int k = 0; k < 8; k++)
            step(1'b0, 1'b1, 4'hF, 3'(k), 8'h01 << k, "one_sweep");
        step(1'b0, 1'b1, 4'h3, 3'd7, 8'h80, "b2b_sel7");
        step(1'b0, 1'b1, 4'h3, 3'd0, 8'h01, "b2b_sel0");
        step(1'b0, 1'b1, 4'h9, 3'd2, 8'h04, "mid_a");
        step(1'b0, 1'b1, 4'h9, 3'd2, 8'h04, "mid_b");
        step(1'b1, 1'b1, 4'h9, 3'd2, 8'h00, "mid_rst");
        step(1'b0, 1'b1, 4'h9, 3'd6, 8'h40, "mid_after");
        step(1'b0, 1'b0, 4'hA, 3'd3, 8'h00, "wide_a");
        checks++;
        assert (out4 === 32'h0000_A000) else begin
            failures++;
            $error("FAIL wide_a_plan out4 got=%h exp=%h", out4, 32'h0000_A000);
        end
        step(1'b0, 1'b0, 4'h5, 3'd7, 8'h00, "wide_b");
        checks++;
        assert (out4 === 32'h5000_0000) else begin
            failures++;
            $error("FAIL wide_b_plan out4 got=%h exp=%h", out4, 32'h5000_0000);
        end
        for (int n = 0; n < 300; n++) begin
            r  = ($urandom_range(0, 15) == 0);
            i1 = 1'($urandom);
            s  = 3'($urandom);
            w  = r ? 8'h00 : (i1 ? (8'h01 << s) : 8'h00);
            step(r, i1, 4'($urandom), s, w, "random");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
